// File: rtl/reg_file_write_ctrl.sv
// Write-port controller for the register file: clears every register after reset, then
// arbitrates write-back (priority) against a debug port with a starvation guard.
module reg_file_write_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_regWrite,
  input  logic [ADDR_W-1:0] wb_reg_num,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_reg_num,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_gnt,
  output logic [ADDR_W-1:0] write_reg_num,
  output logic [DATA_W-1:0] write_data,
  output logic              regWrite,
  output logic              init_done
);

  localparam int WAIT_W = 4;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_n;
  logic                reg_write_n, dbg_gnt_n, init_done_n;
  logic [ADDR_W-1:0]   write_reg_num_n;
  logic [DATA_W-1:0]   write_data_n;
  logic                dbg_eligible, preempt;

  // A debug request is not eligible in its grant cycle, so grants are never back-to-back.
  assign dbg_eligible = dbg_req && !dbg_gnt;
  assign preempt      = (state == RUN) && dbg_eligible && (wait_cnt == WAIT_LIM);
  assign wb_stall     = (state == INIT) || preempt;

  always_comb begin
    state_n         = state;
    clr_cnt_n       = clr_cnt;
    wait_cnt_n      = wait_cnt;
    reg_write_n     = 1'b0;
    write_reg_num_n = write_reg_num;
    write_data_n    = write_data;
    dbg_gnt_n       = 1'b0;
    init_done_n     = init_done;

    case (state)
      INIT: begin
        reg_write_n     = 1'b1;
        write_reg_num_n = clr_cnt;
        write_data_n    = '0;
        clr_cnt_n       = clr_cnt + ADDR_W'(1);
        if (clr_cnt == LAST_REG) begin
          state_n     = RUN;
          init_done_n = 1'b1;
        end
      end
      RUN: begin
        if (preempt || (dbg_eligible && !wb_regWrite)) begin
          reg_write_n     = (dbg_reg_num != '0);
          write_reg_num_n = dbg_reg_num;
          write_data_n    = dbg_data;
          dbg_gnt_n       = 1'b1;
          wait_cnt_n      = '0;
        end else begin
          if (wb_regWrite) begin
            // Register 0 is hardwired zero: the write is dropped but the bus still updates.
            reg_write_n     = (wb_reg_num != '0);
            write_reg_num_n = wb_reg_num;
            write_data_n    = wb_data;
          end
          if (!dbg_req) begin
            wait_cnt_n = '0;
          end else if (dbg_eligible && wb_regWrite && (wait_cnt != WAIT_LIM)) begin
            wait_cnt_n = wait_cnt + WAIT_W'(1);
          end
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= INIT;
      clr_cnt       <= '0;
      wait_cnt      <= '0;
      regWrite      <= 1'b0;
      write_reg_num <= '0;
      write_data    <= '0;
      dbg_gnt       <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      state         <= state_n;
      clr_cnt       <= clr_cnt_n;
      wait_cnt      <= wait_cnt_n;
      regWrite      <= reg_write_n;
      write_reg_num <= write_reg_num_n;
      write_data    <= write_data_n;
      dbg_gnt       <= dbg_gnt_n;
      init_done     <= init_done_n;
    end
  end

endmodule

// File: tb/tb_reg_file_write_ctrl.sv
// Bench for reg_file_write_ctrl: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the write-port arbitration.
module tb_reg_file_write_ctrl;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wb_regWrite = 1'b0;
  logic [ADDR_W-1:0] wb_reg_num = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              wb_stall;
  logic              dbg_req = 1'b0;
  logic [ADDR_W-1:0] dbg_reg_num = '0;
  logic [DATA_W-1:0] dbg_data = '0;
  logic              dbg_gnt;
  logic [ADDR_W-1:0] write_reg_num;
  logic [DATA_W-1:0] write_data;
  logic              regWrite;
  logic              init_done;

  reg_file_write_ctrl #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_regWrite(wb_regWrite), .wb_reg_num(wb_reg_num), .wb_data(wb_data), .wb_stall(wb_stall),
    .dbg_req(dbg_req), .dbg_reg_num(dbg_reg_num), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
    .write_reg_num(write_reg_num), .write_data(write_data), .regWrite(regWrite),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: clear progress, refusal count of the pending debug request,
  // and the outputs expected after each edge.
  bit                m_run = 1'b0;
  int                m_clr = 0;
  int                m_wait = 0;
  bit                m_stall_prev = 1'b1;
  logic              e_rw = 1'b0;
  logic              e_gnt = 1'b0;
  logic              e_done = 1'b0;
  logic [ADDR_W-1:0] e_num = '0;
  logic [DATA_W-1:0] e_dat = '0;

  function automatic bit model_stall();
    return !m_run || (dbg_req && !e_gnt && (m_wait == MAX_WAIT));
  endfunction

  always @(posedge clk) begin : model
    bit debug_wins;
    m_stall_prev = model_stall();
    if (reset) begin
      m_run = 1'b0; m_clr = 0; m_wait = 0;
      e_rw = 1'b0; e_num = '0; e_dat = '0; e_gnt = 1'b0; e_done = 1'b0;
    end else if (!m_run) begin
      e_rw = 1'b1; e_num = ADDR_W'(m_clr); e_dat = '0; e_gnt = 1'b0;
      if (m_clr == NUM_REGS - 1) begin
        m_run = 1'b1;
        e_done = 1'b1;
      end
      m_clr = m_clr + 1;
    end else begin
      debug_wins = dbg_req && !e_gnt && (!wb_regWrite || m_wait == MAX_WAIT);
      if (debug_wins) begin
        e_rw = (dbg_reg_num != 0); e_num = dbg_reg_num; e_dat = dbg_data;
        e_gnt = 1'b1; m_wait = 0;
      end else begin
        if (wb_regWrite) begin
          e_rw = (wb_reg_num != 0); e_num = wb_reg_num; e_dat = wb_data;
        end else begin
          e_rw = 1'b0;
        end
        if (!dbg_req) m_wait = 0;
        else if (!e_gnt && wb_regWrite && m_wait < MAX_WAIT) m_wait = m_wait + 1;
        e_gnt = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_regWrite", regWrite, e_rw);
      check("m_write_reg_num", write_reg_num, e_num);
      check("m_write_data", write_data, e_dat);
      check("m_dbg_gnt", dbg_gnt, e_gnt);
      check("m_init_done", init_done, e_done);
      check("m_wb_stall", wb_stall, model_stall());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rw"}, regWrite, 0);
    check({tag, "_num"}, write_reg_num, 0);
    check({tag, "_dat"}, write_data, 0);
    check({tag, "_gnt"}, dbg_gnt, 0);
    check({tag, "_done"}, init_done, 0);
  endtask

  task automatic run_init();
    for (int i = 0; i < NUM_REGS; i++) begin
      tick();
      check("init_rw", regWrite, 1);
      check("init_num", write_reg_num, i);
      check("init_dat", write_data, 0);
      check("init_done", init_done, (i == NUM_REGS - 1) ? 1 : 0);
      if (i < NUM_REGS - 1) check("init_stall", wb_stall, 1);
    end
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    check_zero("rst");
    check("rst_stall", wb_stall, 1);
    reset = 1'b0;
    run_init();

    tick();
    check("idle_rw", regWrite, 0);
    check("idle_done", init_done, 1);

    // Plain write-back
    wb_regWrite = 1'b1; wb_reg_num = 5'd2; wb_data = 32'h0002FA41;
    check("wb_nostall", wb_stall, 0);
    tick();
    check("wb_rw", regWrite, 1);
    check("wb_num", write_reg_num, 2);
    check("wb_dat", write_data, 32'h0002FA41);
    wb_regWrite = 1'b0;

    // Debug write with the port idle
    dbg_req = 1'b1; dbg_reg_num = 5'd17; dbg_data = 32'hDEADBEEF;
    tick();
    check("dbg_gnt", dbg_gnt, 1);
    check("dbg_rw", regWrite, 1);
    check("dbg_num", write_reg_num, 17);
    check("dbg_dat", write_data, 32'hDEADBEEF);
    dbg_req = 1'b0;
    tick();
    check("dbg_gnt_drop", dbg_gnt, 0);

    // Starvation guard: four WB writes, then debug preempts
    wb_regWrite = 1'b1; wb_reg_num = 5'd3; wb_data = 32'h33;
    dbg_req = 1'b1; dbg_reg_num = 5'd9; dbg_data = 32'h99;
    for (int k = 0; k < MAX_WAIT; k++) begin
      check("starve_stall0", wb_stall, 0);
      tick();
      check("starve_wb_num", write_reg_num, 3);
      check("starve_gnt0", dbg_gnt, 0);
    end
    check("starve_stall1", wb_stall, 1);
    tick();
    check("preempt_gnt", dbg_gnt, 1);
    check("preempt_num", write_reg_num, 9);
    check("preempt_dat", write_data, 32'h99);
    dbg_req = 1'b0;
    tick();
    check("resume_num", write_reg_num, 3);
    check("resume_dat", write_data, 32'h33);
    check("resume_gnt", dbg_gnt, 0);

    // Register 0 is never written
    wb_reg_num = 5'd0; wb_data = 32'h12345678;
    tick();
    check("r0_wb_rw", regWrite, 0);
    check("r0_wb_dat", write_data, 32'h12345678);
    wb_regWrite = 1'b0;
    dbg_req = 1'b1; dbg_reg_num = 5'd0; dbg_data = 32'hCAFE;
    tick();
    check("r0_dbg_gnt", dbg_gnt, 1);
    check("r0_dbg_rw", regWrite, 0);
    dbg_req = 1'b0;

    // Reset in the middle of the clear sequence
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("mid_init_num", write_reg_num, 9);
    reset = 1'b1;
    tick();
    check_zero("rst_init");
    reset = 1'b0;
    run_init();

    // Reset in the middle of a debug grant
    dbg_req = 1'b1; dbg_reg_num = 5'd5; dbg_data = 32'h55;
    tick();
    check("pre_rst_gnt", dbg_gnt, 1);
    reset = 1'b1; dbg_req = 1'b0;
    tick();
    check_zero("rst_gnt");
    reset = 1'b0;
    run_init();

    // Randomized traffic respecting both handshakes
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      if (dbg_req && e_gnt) begin
        dbg_req = 1'b0;
      end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1'b1;
        dbg_reg_num = ($urandom_range(0, 7) == 0) ? 5'd0 : ADDR_W'($urandom_range(0, 31));
        dbg_data = $urandom;
      end
      if (!m_stall_prev) begin
        wb_regWrite = ($urandom_range(0, 3) != 0);
        wb_reg_num = ($urandom_range(0, 7) == 0) ? 5'd0 : ADDR_W'($urandom_range(0, 31));
        wb_data = $urandom;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
